// File: rtl/fifo_read_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_port_pkg
// Brief    : Shared default parameters and helpers for the CBG FIFO read port
// Revision : 1.0 - initial release
// ============================================================================
package fifo_read_port_pkg;

    // Storage FIFO depth; the address width is derived from it
    localparam int c_F_D = 16;
    localparam int c_A_W = $clog2(c_F_D);
    // Data word width
    localparam int c_D_W = 32;
    // Output queue depth (power of two, at least 2)
    localparam int c_Q_D = 4;

    // Occupancy counter width: must hold the value Q_D itself
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_read_port_pkg
`default_nettype wire

// File: rtl/fifo_read_port_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_port_if
// Brief    : Storage-RAM read bus and downstream valid/ready bus of the
//            FIFO read port
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_read_port_if
    import fifo_read_port_pkg::*;
#(
    parameter int A_W = c_A_W,
    parameter int D_W = c_D_W
);

    logic           mem_ren;
    logic [A_W-1:0] mem_raddr;
    logic [D_W-1:0] mem_rdata;
    logic           out_valid;
    logic [D_W-1:0] out_data;
    logic           out_ready;

    // Read port side: issues RAM reads and sources the output stream
    modport master (
        output mem_ren,
        output mem_raddr,
        input  mem_rdata,
        output out_valid,
        output out_data,
        input  out_ready
    );

    // RAM plus downstream consumer side
    modport slave (
        input  mem_ren,
        input  mem_raddr,
        output mem_rdata,
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface : fifo_read_port_if
`default_nettype wire

// File: rtl/fifo_read_port_rdq_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rdq_buffer
// Brief    : Q_D-entry circular output queue with drop-on-full and a sticky
//            overrun flag
// Revision : 1.0 - initial release
// ============================================================================
module rdq_buffer
    import fifo_read_port_pkg::*;
#(
    parameter int D_W   = c_D_W,
    parameter int Q_D   = c_Q_D,
    parameter int CNT_W = cnt_width(c_Q_D)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             i_push,
    input  wire logic [D_W-1:0]   i_push_data,
    input  wire logic             i_pop_ready,
    output logic                  o_valid,
    output logic [D_W-1:0]        o_data,
    output logic [CNT_W-1:0]      o_cnt,
    output logic                  o_overrun
);

    localparam int               c_PW   = $clog2(Q_D);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(Q_D);

    logic [D_W-1:0]   r_mem [Q_D];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overrun;

    logic w_full;
    logic w_pop;
    logic w_write;

    assign w_full  = (r_cnt == c_FULL);
    assign o_valid = (r_cnt != '0);
    assign w_pop   = o_valid & i_pop_ready;
    // A push lands when there is room, or when the head leaves in the same
    // cycle (at full the write slot is the one being popped)
    assign w_write = i_push & (w_pop | ~w_full);

    assign o_data    = r_mem[r_rptr];
    assign o_cnt     = r_cnt;
    assign o_overrun = r_overrun;

    // Pointer, occupancy and overrun bookkeeping; flush keeps the sticky flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_push && w_pop) begin
            r_wptr <= r_wptr + c_PW'(1);
            r_rptr <= r_rptr + c_PW'(1);
        end else if (i_push && !w_full) begin
            r_wptr <= r_wptr + c_PW'(1);
            r_cnt  <= r_cnt + CNT_W'(1);
        end else if (i_push) begin
            r_overrun <= 1'b1;
        end else if (w_pop) begin
            r_rptr <= r_rptr + c_PW'(1);
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Queue storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < Q_D; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_write) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

endmodule : rdq_buffer
`default_nettype wire

// File: rtl/fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_port
// Brief    : Read-side consumer of the CBG FIFO: requests reads, forwards
//            grants to the storage RAM and queues returned words for the PE
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_port
    import fifo_read_port_pkg::*;
#(
    parameter int A_W = c_A_W,
    parameter int D_W = c_D_W,
    parameter int Q_D = c_Q_D
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           en,
    input  wire logic           flush,
    output logic                re,
    input  wire logic           re_n,
    input  wire logic [A_W-1:0] rd_addr,
    fifo_read_port_if.master    bus,
    output logic                overrun
);

    localparam int c_CW = cnt_width(Q_D);

    logic            r_rd_pend;
    logic [c_CW-1:0] w_q_cnt;
    logic [c_CW:0]   w_committed;

    // Grants, including forced almost-full reads, go straight to the RAM
    assign bus.mem_ren   = re_n;
    assign bus.mem_raddr = rd_addr;

    // Marks mem_rdata as carrying a granted word in the following cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= re_n & ~flush;
        end
    end

    // Queued plus in-flight words, one bit wider than the counter so the sum
    // never truncates; a same-cycle pop is deliberately not credited
    assign w_committed = {1'b0, w_q_cnt} + {{c_CW{1'b0}}, r_rd_pend};
    assign re          = en & rst & ~flush & (w_committed < (c_CW+1)'(Q_D));

    rdq_buffer #(
        .D_W   (D_W),
        .Q_D   (Q_D),
        .CNT_W (c_CW)
    ) u_rdq_buffer (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .i_push      (r_rd_pend),
        .i_push_data (bus.mem_rdata),
        .i_pop_ready (bus.out_ready),
        .o_valid     (bus.out_valid),
        .o_data      (bus.out_data),
        .o_cnt       (w_q_cnt),
        .o_overrun   (overrun)
    );

endmodule : fifo_read_port
`default_nettype wire

// File: tb/tb_fifo_read_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_port
// Brief    : Self-checking bench for fifo_read_port with a small model of
//            address_update and the storage RAM
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_port;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       re;
    logic       re_n;
    logic [3:0] rd_addr;
    logic       overrun;

    fifo_read_port_if #(.A_W(4), .D_W(32)) bus ();

    fifo_read_port #(.A_W(4), .D_W(32), .Q_D(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .re      (re),
        .re_n    (re_n),
        .rd_addr (rd_addr),
        .bus     (bus),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Storage RAM model: one-cycle read latency
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    // address_update model state
    int rd_ptr, wr_ptr, avail, wseq;
    bit force_rn;
    int checks, errors;

    typedef struct {
        bit          en;
        bit          ready;
        bit          flush;
        int          wr;
        bit          exp_re;
        bit          exp_valid;
        logic [31:0] exp_data;
        int          exp_addr;
    } vec_t;
    vec_t vt [17];

    function automatic logic [31:0] dw(input int k);
        return 32'hA5A5_0001 + 32'(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr_words(input int n);
        for (int i = 0; i < n; i++) begin
            ram[wr_ptr] = dw(wseq);
            wseq++;
            wr_ptr = (wr_ptr + 1) % 16;
            avail++;
        end
    endtask

    // Grant whenever requested and data is available, or when forced
    task automatic drive();
        rd_addr = rd_ptr[3:0];
        #1;
        re_n = force_rn | (re & (avail > 0));
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        if (re_n) begin
            rd_ptr = (rd_ptr + 1) % 16;
            avail--;
        end
        @(negedge clk);
    endtask

    initial begin
        int base, nxt, to_write, exp_seq, got, first_v, last_v, prev_addr;
        bit wrapped;
        clk = 0; rst = 0; en = 1; flush = 0; re_n = 0; rd_addr = 0;
        force_rn = 0; bus.out_ready = 0;
        rd_ptr = 0; wr_ptr = 0; avail = 0; wseq = 0; checks = 0; errors = 0;

        //            en rdy fl wr re v  data           addr
        vt[0]  = '{1, 0, 0, 1, 1, 0, 32'h0,      0};
        vt[1]  = '{1, 0, 0, 0, 1, 0, 32'h0,     -1};
        vt[2]  = '{1, 1, 0, 0, 1, 1, dw(0),     -1};
        vt[3]  = '{1, 0, 0, 0, 1, 0, 32'h0,     -1};
        vt[4]  = '{1, 0, 0, 6, 1, 0, 32'h0,      1};
        vt[5]  = '{1, 0, 0, 0, 1, 0, 32'h0,      2};
        vt[6]  = '{1, 0, 0, 0, 1, 1, dw(1),      3};
        vt[7]  = '{1, 0, 0, 0, 1, 1, dw(1),      4};
        vt[8]  = '{1, 0, 0, 0, 0, 1, dw(1),     -1};
        vt[9]  = '{1, 0, 0, 0, 0, 1, dw(1),     -1};
        vt[10] = '{1, 1, 0, 0, 0, 1, dw(1),     -1};
        vt[11] = '{1, 1, 0, 0, 1, 1, dw(2),      5};
        vt[12] = '{1, 1, 0, 0, 1, 1, dw(3),      6};
        vt[13] = '{1, 1, 0, 0, 1, 1, dw(4),     -1};
        vt[14] = '{1, 1, 0, 0, 1, 1, dw(5),     -1};
        vt[15] = '{1, 1, 0, 0, 1, 1, dw(6),     -1};
        vt[16] = '{1, 0, 0, 0, 1, 0, 32'h0,     -1};

        // Reset: request gated, RAM enable follows the grant line
        @(negedge clk);
        #1;
        chk("rst_re_gated", {31'b0, re}, 32'd0);
        re_n = 1;
        #1;
        chk("rst_mem_ren_follows", {31'b0, bus.mem_ren}, 32'd1);
        re_n = 0;
        step();
        #1;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        rst = 1;

        // Single read and back-pressure, cycle by cycle
        for (int i = 0; i < 17; i++) begin
            en = vt[i].en; bus.out_ready = vt[i].ready; flush = vt[i].flush;
            wr_words(vt[i].wr);
            drive();
            chk($sformatf("v%0d_re", i), {31'b0, re}, {31'b0, vt[i].exp_re});
            chk($sformatf("v%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].exp_valid});
            if (vt[i].exp_valid) chk($sformatf("v%0d_data", i), bus.out_data, vt[i].exp_data);
            if (vt[i].exp_addr >= 0) begin
                chk($sformatf("v%0d_mem_ren", i), {31'b0, bus.mem_ren}, 32'd1);
                chk($sformatf("v%0d_mem_raddr", i), {28'b0, bus.mem_raddr}, 32'(vt[i].exp_addr));
            end
            step();
        end

        // Streaming 40 words through the wrapping storage
        bus.out_ready = 1; en = 1;
        to_write = 40; exp_seq = wseq; got = 0; first_v = -1; last_v = -1;
        prev_addr = -1; wrapped = 0;
        for (int cyc = 0; cyc < 120 && got < 40; cyc++) begin
            if (to_write > 0 && avail < 16) begin
                wr_words(1);
                to_write--;
            end
            drive();
            if (re_n) begin
                if (prev_addr == 15 && bus.mem_raddr == 4'd0) wrapped = 1;
                prev_addr = int'(bus.mem_raddr);
            end
            if (bus.out_valid) begin
                chk("stream_data", bus.out_data, dw(exp_seq));
                exp_seq++;
                got++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            step();
        end
        chk("stream_count", 32'(got), 32'd40);
        chk("stream_wrap", {31'b0, wrapped}, 32'd1);
        chk("stream_fill_latency", 32'(first_v), 32'd2);
        chk("stream_one_per_cycle", 32'(last_v - first_v), 32'd39);

        // Forced read into a full queue is dropped and flagged
        bus.out_ready = 0;
        base = wseq;
        wr_words(5);
        repeat (6) begin
            drive();
            step();
        end
        drive();
        chk("full_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("full_head", bus.out_data, dw(base));
        chk("full_re_low", {31'b0, re}, 32'd0);
        force_rn = 1;
        drive();
        chk("force_re_low", {31'b0, re}, 32'd0);
        chk("force_mem_ren", {31'b0, bus.mem_ren}, 32'd1);
        step();
        force_rn = 0;
        drive();
        chk("overrun_not_yet", {31'b0, overrun}, 32'd0);
        step();
        bus.out_ready = 1;
        drive();
        chk("overrun_set", {31'b0, overrun}, 32'd1);
        chk("overrun_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("overrun_head_kept", bus.out_data, dw(base));
        step();
        for (int k = 1; k < 4; k++) begin
            drive();
            chk($sformatf("drain%0d_data", k), bus.out_data, dw(base + k));
            chk($sformatf("drain%0d_valid", k), {31'b0, bus.out_valid}, 32'd1);
            step();
        end
        drive();
        chk("drain_dropped_absent", {31'b0, bus.out_valid}, 32'd0);
        step();

        // Flush with a read in flight
        wr_words(1);
        drive();
        chk("flush_pre_re", {31'b0, re}, 32'd1);
        chk("flush_pre_grant", {31'b0, bus.mem_ren}, 32'd1);
        step();
        flush = 1;
        drive();
        chk("flush_re_low", {31'b0, re}, 32'd0);
        step();
        flush = 0;
        nxt = wseq;
        wr_words(1);
        drive();
        chk("flush_valid_low", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_overrun_kept", {31'b0, overrun}, 32'd1);
        step();
        drive();
        chk("flush_next_wait", {31'b0, bus.out_valid}, 32'd0);
        step();
        drive();
        chk("flush_next_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("flush_next_data", bus.out_data, dw(nxt));
        step();

        // Reset in the middle of operation
        bus.out_ready = 0;
        base = wseq;
        wr_words(3);
        repeat (5) begin
            drive();
            step();
        end
        drive();
        chk("prerst_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("prerst_head", bus.out_data, dw(base));
        rst = 0;
        drive();
        chk("midrst_re", {31'b0, re}, 32'd0);
        step();
        drive();
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_data", bus.out_data, 32'd0);
        chk("midrst_overrun", {31'b0, overrun}, 32'd0);
        chk("midrst_re_hold", {31'b0, re}, 32'd0);
        rst = 1;
        nxt = wseq;
        wr_words(1);
        drive();
        chk("postrst_re", {31'b0, re}, 32'd1);
        step();
        drive();
        step();
        drive();
        chk("postrst_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("postrst_data", bus.out_data, dw(nxt));
        bus.out_ready = 1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_read_port
`default_nettype wire
